video_line_buffer: RTL and testbench
====================================

VIDEO_LINE_BUFFER -- requirements
Module: video_line_buffer

Interface
REQ-001 Parameter ACTIVE_W, default 320: visible pixels per line; writes with wr_x >= ACTIVE_W are dropped.
REQ-002 Parameter CLR_LEN, default 512: entries per bank and length of the post-reset clear sweep.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 hc  in  9  horizontal counter from video timing.
REQ-006 vc  in  9  vertical counter from video timing.
REQ-007 hbl  in  1  horizontal blank from video timing.
REQ-008 vbl  in  1  vertical blank from video timing.
REQ-009 wr_valid  in  1  renderer pixel write request.
REQ-010 wr_ready  out  1  write accepted when wr_valid & wr_ready.
REQ-011 wr_x  in  9  pixel x position.
REQ-012 wr_color  in  11  palette index; low nibble 0 means transparent.
REQ-013 wr_pri  in  3  priority; higher or equal wins.
REQ-014 line_req  out  1  one-cycle pulse requesting render of the next line.
REQ-015 line_num  out  9  line to render, valid while line_req is high.
REQ-016 pix_color  out  11  display pixel palette index.
REQ-017 pix_opaque  out  1  display pixel is non-empty.

Function
REQ-018 Storage: two banks of CLR_LEN entries {opaque 1b, pri 3b, color 11b}; disp_bank selects the displayed bank; the other bank is the render bank.
REQ-019 FSM states: CLEAR and RUN; reset enters CLEAR with clr_addr=0.
REQ-020 CLEAR: writes empty (all-zero) to address clr_addr in both banks each cycle; wr_ready=0; line_req=0; after clr_addr==CLR_LEN-1, go to RUN.
REQ-021 Swap: in RUN, hbl rising edge (hbl=1 with hbl registered previous=0) toggles disp_bank and pulses line_req for exactly one cycle in that same cycle.
REQ-022 line_num = 0 when vc+1 >= first vbl line (vbl=1 at swap) else vc+1, 9-bit.
REQ-023 Write pipeline, 2 stages: S1 latches x, color, pri and the target bank (current render bank) and reads the stored entry; S2 writes the new entry iff wr_x < ACTIVE_W, color[3:0] != 0, and (stored opaque==0 or wr_pri >= stored pri).
REQ-024 Hazard: if S1 and S2 target the same bank and same x, S1 compares against the S2 result (forwarding), never the stale RAM value.
REQ-025 wr_ready=1 in RUN except in the swap cycle and the cycle after it.
REQ-026 A write in flight at swap completes into its latched bank; accepted writes after swap target the new render bank.
REQ-027 Display read: disp_bank entry at address hc is read every cycle; pix_color/pix_opaque are registered with latency exactly 2 cycles from hc.
REQ-028 Clear-behind-read: the display entry read at hc is written empty one cycle later, so the bank is empty when it returns as render bank.
REQ-029 Blanking: if hbl or vbl, delayed by 2 cycles to align with the pixel, is 1, pix_color=0 and pix_opaque=0.
REQ-030 Address wrap: hc and wr_x index modulo CLR_LEN; no out-of-range access.

Reset
REQ-031 On reset: pix_color=0, pix_opaque=0, line_req=0, line_num=0, wr_ready=0, disp_bank=0, pipeline valid bits=0, state=CLEAR.
REQ-032 Reset asserted mid-line or mid-write discards in-flight writes and restarts the full clear sweep.
REQ-033 RAM contents are defined only via the clear sweep, never by reset directly.

Verification
REQ-034 Reset, then count cycles -> wr_ready=0 for exactly 512 cycles, then 1; every displayed pixel of the first line has pix_opaque=0.
REQ-035 Write x=10 color 0x125 pri 2, then x=10 color 0x0A1 pri 1, swap -> at hc=10 output is 0x125 opaque 2 cycles later.
REQ-036 Back-to-back writes x=5 pri 1 color 0x011, then x=5 pri 3 color 0x033 -> displays 0x033 (forwarding exercised).
REQ-037 Writes with color 0x120 and with x=330 -> no change; displayed pixel stays transparent.
REQ-038 hbl rising at vc=100 -> one-cycle line_req with line_num=101, wr_ready low for 2 cycles; the line displayed after two swaps is fully empty.
REQ-039 Assert reset while wr_valid streams mid-line -> all outputs return to reset values next cycle; no pre-reset pixel is displayed afterwards.

Source files
------------

// File: rtl/video_line_buffer_if.sv
// Renderer-side pixel write channel into the line buffer.
interface video_line_buffer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_x;
  logic [10:0] wr_color;
  logic [2:0]  wr_pri;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_color,
    output wr_pri,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_color,
    input  wr_pri,
    output wr_ready
  );
endinterface

// File: rtl/video_line_buffer.sv
// Double-banked scanline buffer. The renderer composites pixels into one
// bank by priority while the other bank is scanned out and erased behind
// the beam. Banks swap on every rising edge of hbl.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | post-reset sweep, zeroing one address of both banks/cycle
// ST_RUN   | normal operation: render writes, scan-out, swaps on hbl
module video_line_buffer #(
  parameter int ACTIVE_W = 320,
  parameter int CLR_LEN  = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hc,
  input  logic [8:0]  vc,
  input  logic        hbl,
  input  logic        vbl,
  video_line_buffer_if.slave wr,
  output logic        line_req,
  output logic [8:0]  line_num,
  output logic [10:0] pix_color,
  output logic        pix_opaque
);
  localparam int AW = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;
  localparam logic [AW-1:0] CLR_LAST = AW'(CLR_LEN - 1);

  typedef struct packed {
    logic        opaque;
    logic [2:0]  pri;
    logic [10:0] color;
  } entry_t;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [AW-1:0] wrap_addr(input logic [8:0] v);
    return AW'(32'(v) % 32'(CLR_LEN));
  endfunction

  entry_t mem [2][CLR_LEN];

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q;
  logic          disp_bank_q;
  logic          hbl_q;
  logic          swap_q;
  logic          swap;
  logic          clr_we;
  logic          ready;

  // Sequencer state, sweep address, bank select and hbl/swap history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      disp_bank_q <= 1'b0;
      hbl_q       <= 1'b0;
      swap_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clr_we) clr_addr_q <= clr_addr_q + AW'(1);
      hbl_q  <= hbl;
      swap_q <= swap;
      if (swap) disp_bank_q <= ~disp_bank_q;
    end
  end

  // Next-state and control decode; ready stays low for the swap cycle and
  // the one after so no new write can collide with the bank turnaround
  always_comb begin
    state_d  = state_q;
    clr_we   = 1'b0;
    swap     = 1'b0;
    ready    = 1'b0;
    line_req = 1'b0;
    line_num = '0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_addr_q == CLR_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        swap     = hbl & ~hbl_q;
        ready    = ~swap & ~swap_q;
        line_req = swap;
        if (swap && !vbl) line_num = vc + 9'd1;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign wr.wr_ready = ready;

  // Write pipeline registers (S1 holds one accepted write awaiting S2)
  logic          s1_valid;
  logic          s1_bank;
  logic [AW-1:0] s1_addr;
  logic [8:0]    s1_x;
  logic [10:0]   s1_color;
  logic [2:0]    s1_pri;
  entry_t        s1_stored;

  logic          accept;
  logic          render_bank;
  logic [AW-1:0] wr_addr;
  entry_t        ram_q;
  entry_t        fwd;
  entry_t        s2_new;
  entry_t        s2_result;
  logic          s2_win;

  // S2 priority decision, plus forwarding of its result into the S1 read
  // when the incoming write hits the same bank and address
  always_comb begin
    accept      = wr.wr_valid & ready;
    render_bank = ~disp_bank_q;
    wr_addr     = wrap_addr(wr.wr_x);
    s2_new      = '{opaque: 1'b1, pri: s1_pri, color: s1_color};
    s2_win      = s1_valid
                  && (32'(s1_x) < 32'(ACTIVE_W))
                  && (s1_color[3:0] != 4'h0)
                  && (!s1_stored.opaque || (s1_pri >= s1_stored.pri));
    s2_result   = s2_win ? s2_new : s1_stored;
    ram_q       = mem[render_bank][wr_addr];
    fwd         = (s1_valid && (s1_bank == render_bank) && (s1_addr == wr_addr))
                  ? s2_result : ram_q;
  end

  // S1 capture: the target bank is frozen here so a write in flight across
  // a swap still lands in the bank it was aimed at
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
    if (accept) begin
      s1_bank   <= render_bank;
      s1_addr   <= wr_addr;
      s1_x      <= wr.wr_x;
      s1_color  <= wr.wr_color;
      s1_pri    <= wr.wr_pri;
      s1_stored <= fwd;
    end
  end

  // Display read stage; address and bank are kept for the erase one cycle on
  logic          rd_run_d1;
  logic          rd_bank_d1;
  logic          blank_d1;
  logic [AW-1:0] rd_addr_d1;
  logic [AW-1:0] hc_addr;
  logic [10:0]   rd_color_d1;
  logic          rd_opaque_d1;

  assign hc_addr = wrap_addr(hc);

  // Scan-out read of the display bank at hc
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_run_d1 <= 1'b0;
      blank_d1  <= 1'b0;
    end else begin
      rd_run_d1 <= (state_q == ST_RUN);
      blank_d1  <= hbl | vbl;
    end
    rd_bank_d1   <= disp_bank_q;
    rd_addr_d1   <= hc_addr;
    rd_color_d1  <= mem[disp_bank_q][hc_addr].color;
    rd_opaque_d1 <= mem[disp_bank_q][hc_addr].opaque;
  end

  // Output register; blank_d1 plus this stage puts hbl/vbl two cycles back,
  // in step with the pixel fetched at the same hc
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_color  <= '0;
      pix_opaque <= 1'b0;
    end else if (rd_run_d1 && !blank_d1) begin
      pix_color  <= rd_color_d1;
      pix_opaque <= rd_opaque_d1;
    end else begin
      pix_color  <= '0;
      pix_opaque <= 1'b0;
    end
  end

  // RAM writes: clear sweep, erase-behind-scan and the S2 pixel write.
  // Erase and S2 never meet on one bank in a cycle because of the ready gap.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[1'b0][clr_addr_q] <= '0;
      mem[1'b1][clr_addr_q] <= '0;
    end else if (!reset) begin
      if (rd_run_d1) mem[rd_bank_d1][rd_addr_d1] <= '0;
      if (s2_win)    mem[s1_bank][s1_addr]       <= s2_result;
    end
  end
endmodule

// File: tb/tb_video_line_buffer.sv
module tb_video_line_buffer;
  localparam int ACTIVE_W = 320;
  localparam int CLR_LEN  = 512;
  localparam int H_TOTAL  = 400;
  localparam int N_CYC    = 16000;
  localparam int RST_AT   = 9100;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  hc    = '0;
  logic [8:0]  vc    = '0;
  logic        hbl   = 1'b0;
  logic        vbl   = 1'b0;
  logic        line_req;
  logic [8:0]  line_num;
  logic [10:0] pix_color;
  logic        pix_opaque;

  video_line_buffer_if wr_if ();

  video_line_buffer #(.ACTIVE_W(ACTIVE_W), .CLR_LEN(CLR_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .hc         (hc),
    .vc         (vc),
    .hbl        (hbl),
    .vbl        (vbl),
    .wr         (wr_if),
    .line_req   (line_req),
    .line_num   (line_num),
    .pix_color  (pix_color),
    .pix_opaque (pix_opaque)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       rdy;
    logic       lreq;
    logic [8:0] lnum;
  } comb_exp_t;

  typedef struct {
    int          due;
    logic [10:0] color;
    logic        opaque;
  } pix_exp_t;

  typedef struct {
    int          x;
    logic [10:0] c;
    logic [2:0]  p;
  } wreq_t;

  comb_exp_t comb_q[$];
  pix_exp_t  pix_q[$];
  wreq_t     dq[$];

  int checks = 0;
  int errors = 0;

  // Reference model: two line arrays of pixels, written in acceptance order
  logic [10:0] m_color [2][CLR_LEN];
  logic [2:0]  m_pri   [2][CLR_LEN];
  bit          m_opq   [2][CLR_LEN];
  int          m_disp = 0;
  int          m_cnt  = 0;
  bit          m_prev_hbl  = 1'b0;
  bit          m_prev_swap = 1'b0;

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < CLR_LEN; a++) begin
        m_color[b][a] = '0;
        m_pri[b][a]   = '0;
        m_opq[b][a]   = 1'b0;
      end
  endtask

  task automatic model_write(input int b, input int x, input logic [10:0] c, input logic [2:0] p);
    int a;
    if (x >= ACTIVE_W) return;
    if (c[3:0] == 4'h0) return;
    a = x % CLR_LEN;
    if (!m_opq[b][a] || p >= m_pri[b][a]) begin
      m_color[b][a] = c;
      m_pri[b][a]   = p;
      m_opq[b][a]   = 1'b1;
    end
  endtask

  // One cycle of the reference: predicts this cycle's handshake/line outputs
  // and the pixel that will appear two cycles later
  task automatic model_step(output bit acc);
    bit         run, swap, rdy;
    logic [8:0] lnum;
    int         a;
    comb_exp_t  ce;
    pix_exp_t   pe;
    run  = (m_cnt >= CLR_LEN);
    swap = run && hbl && !m_prev_hbl;
    rdy  = run && !swap && !m_prev_swap;
    lnum = (swap && !vbl) ? 9'(vc + 9'd1) : 9'd0;
    ce.due = cyc; ce.rdy = rdy; ce.lreq = swap; ce.lnum = lnum;
    comb_q.push_back(ce);
    acc = wr_if.wr_valid && rdy;
    if (acc) model_write(1 - m_disp, int'(wr_if.wr_x), wr_if.wr_color, wr_if.wr_pri);
    pe.due = cyc + 2; pe.color = '0; pe.opaque = 1'b0;
    if (run) begin
      a = int'(hc) % CLR_LEN;
      if (!(hbl || vbl)) begin
        pe.color  = m_opq[m_disp][a] ? m_color[m_disp][a] : 11'd0;
        pe.opaque = m_opq[m_disp][a];
      end
      m_color[m_disp][a] = '0;
      m_pri[m_disp][a]   = '0;
      m_opq[m_disp][a]   = 1'b0;
    end
    if (reset) begin
      pe.color = '0; pe.opaque = 1'b0;
      foreach (pix_q[i])
        if (pix_q[i].due > cyc) begin
          pix_q[i].color  = '0;
          pix_q[i].opaque = 1'b0;
        end
    end
    pix_q.push_back(pe);
    if (swap) m_disp = 1 - m_disp;
    m_prev_hbl  = hbl;
    m_prev_swap = swap;
    if (reset) begin
      model_clear();
      m_disp = 0; m_cnt = 0; m_prev_hbl = 1'b0; m_prev_swap = 1'b0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic load_directed();
    dq.push_back('{10,  11'h125, 3'd2});
    dq.push_back('{10,  11'h0A1, 3'd1});
    dq.push_back('{5,   11'h011, 3'd1});
    dq.push_back('{5,   11'h033, 3'd3});
    dq.push_back('{20,  11'h120, 3'd7});
    dq.push_back('{330, 11'h155, 3'd7});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Stimulus: video timing, randomized renderer writes, mid-line reset
  initial begin
    int    hpos, vline, last_x;
    bit    have, quiet, acc;
    wreq_t cur;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_x     = '0;
    wr_if.wr_color = '0;
    wr_if.wr_pri   = '0;
    model_clear();
    load_directed();
    have   = 1'b0;
    last_x = 0;
    cur    = '{0, 11'h0, 3'd0};
    for (int n = 0; n < N_CYC; n++) begin
      @(posedge clk); #1;
      hpos  = n % H_TOTAL;
      vline = n / H_TOTAL;
      hc    = 9'(hpos);
      hbl   = (hpos >= ACTIVE_W);
      vc    = 9'(97 + vline % 10);
      vbl   = (vc >= 9'd104);
      reset = (n < 3) || (n >= RST_AT && n < RST_AT + 2);
      if (n == RST_AT) load_directed();
      quiet = (vline % 7 == 3);
      if (!have) begin
        if (dq.size() > 0) begin
          cur  = dq.pop_front();
          have = 1'b1;
        end else if ($urandom_range(0, 9) < 7) begin
          int r;
          r = $urandom_range(0, 99);
          if (r < 25)      cur.x = last_x;
          else if (r < 35) cur.x = $urandom_range(ACTIVE_W, 511);
          else             cur.x = $urandom_range(0, ACTIVE_W - 1);
          cur.c = 11'($urandom);
          if ($urandom_range(0, 9) == 0) cur.c[3:0] = 4'h0;
          cur.p = 3'($urandom);
          have  = 1'b1;
        end
      end
      wr_if.wr_valid = have && !quiet;
      wr_if.wr_x     = 9'(cur.x);
      wr_if.wr_color = cur.c;
      wr_if.wr_pri   = cur.p;
      model_step(acc);
      if (acc) begin
        have   = 1'b0;
        last_x = cur.x;
      end
    end
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("comb_q_drained", 16'(comb_q.size()), 16'd0);
    chk("pix_q_drained", 16'(pix_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: compares DUT outputs against expectations as they fall due
  int rl_cnt = 0;
  bit rl_arm = 1'b0;
  always @(negedge clk) begin : mon
    comb_exp_t ce;
    pix_exp_t  pe;
    if (comb_q.size() > 0 && comb_q[0].due == cyc) begin
      ce = comb_q.pop_front();
      chk("wr_ready", 16'(wr_if.wr_ready), 16'(ce.rdy));
      chk("line_req", 16'(line_req), 16'(ce.lreq));
      if (ce.lreq) chk("line_num", 16'(line_num), 16'(ce.lnum));
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      pe = pix_q.pop_front();
      chk("pix_color", 16'(pix_color), 16'(pe.color));
      chk("pix_opaque", 16'(pix_opaque), 16'(pe.opaque));
    end
    if (reset) begin
      rl_cnt = 0;
      rl_arm = 1'b1;
    end else if (rl_arm) begin
      if (wr_if.wr_ready === 1'b1) begin
        chk("clear_len", 16'(rl_cnt), 16'(CLR_LEN));
        rl_arm = 1'b0;
      end else begin
        rl_cnt++;
        if (rl_cnt > 2 * CLR_LEN) begin
          chk("clear_len", 16'(rl_cnt), 16'(CLR_LEN));
          rl_arm = 1'b0;
        end
      end
    end
  end
endmodule
